// File: rtl/mpmc11_pkg.sv
// mpmc11_pkg: shared types for the mpmc11 memory controller.
//   mpmc11_state_t      - controller state machine encoding (sm_state)
//   mpmc11_coll_state_t - read-response collector states
//   MPMC11_RESP_LAT_W   - width of the arm-to-last-beat latency counter
package mpmc11_pkg;

  typedef enum logic [3:0] {
    IDLE,
    PRECHARGE,
    ACTIVATE,
    PRESET1,
    PRESET2,
    PRESET3,
    RD_WAIT,
    WR_DATA,
    REFRESH
  } mpmc11_state_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_COLLECT,
    C_DONE,
    C_HOLD
  } mpmc11_coll_state_t;

  localparam int MPMC11_RESP_LAT_W = 16;

endpackage

// File: rtl/mpmc11_rd_resp_collector.sv
// mpmc11_rd_resp_collector: assembles DDR application read beats into one line
// and hands it to the requesting channel (valid/ready) or to the RMW/ALU path.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   sm_state            controller state; PRESET3 arms, IDLE during collect aborts
//   cmd_cyc/cmd_we      latched command bits; a read arms the collector
//   cmd_rmw, cmd_tid    latched at arm: destination select and transaction id
//   burst_len           beats-1 of the burst, latched at arm
//   rd_data_valid/rd_data  application read-beat stream
//   resp_burst_cnt      beats received before the current one
//   resp_v/resp_rdy     channel response handshake; resp_tid/resp_line/resp_err held
//   rmw_v               one-cycle pulse, line valid for the ALU path
//   busy                collector not idle
//   stray_err           one-cycle pulse, beat seen outside collection
//   resp_lat            arm-to-last-beat latency
//
// Optional feature macro: MPMC11_RESP_LATENCY_EN builds the latency counter;
// without it resp_lat is tied to zero.
module mpmc11_rd_resp_collector
  import mpmc11_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int MAX_BEATS = 2,
  parameter int TID_W     = 13
) (
  input  logic                          clk,
  input  logic                          rst,
  input  mpmc11_state_t                 sm_state,
  input  logic                          cmd_cyc,
  input  logic                          cmd_we,
  input  logic                          cmd_rmw,
  input  logic [TID_W-1:0]              cmd_tid,
  input  logic [7:0]                    burst_len,
  input  logic                          rd_data_valid,
  input  logic [DATA_W-1:0]             rd_data,
  output logic [7:0]                    resp_burst_cnt,
  output logic                          resp_v,
  input  logic                          resp_rdy,
  output logic [TID_W-1:0]              resp_tid,
  output logic [DATA_W*MAX_BEATS-1:0]   resp_line,
  output logic                          resp_err,
  output logic                          rmw_v,
  output logic                          busy,
  output logic                          stray_err,
  output logic [MPMC11_RESP_LAT_W-1:0]  resp_lat
);

  mpmc11_coll_state_t state_reg, state_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic [7:0]       blen_reg, blen_next;
  logic             rmw_reg, rmw_next;
  logic [TID_W-1:0] tid_reg, tid_next;
  logic             err_reg, err_next;
  logic             resp_v_reg, resp_v_next;
  logic             rmw_v_reg, rmw_v_next;
  logic             stray_reg, stray_next;
  logic             busy_reg;
  logic             beat_we;
  logic             arm;

  assign arm = (sm_state == PRESET3) && cmd_cyc && !cmd_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= C_IDLE;
      cnt_reg    <= '0;
      blen_reg   <= '0;
      rmw_reg    <= 1'b0;
      tid_reg    <= '0;
      err_reg    <= 1'b0;
      resp_v_reg <= 1'b0;
      rmw_v_reg  <= 1'b0;
      stray_reg  <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      blen_reg   <= blen_next;
      rmw_reg    <= rmw_next;
      tid_reg    <= tid_next;
      err_reg    <= err_next;
      resp_v_reg <= resp_v_next;
      rmw_v_reg  <= rmw_v_next;
      stray_reg  <= stray_next;
      busy_reg   <= (state_next != C_IDLE);
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    blen_next   = blen_reg;
    rmw_next    = rmw_reg;
    tid_next    = tid_reg;
    err_next    = err_reg;
    resp_v_next = resp_v_reg;
    rmw_v_next  = 1'b0;
    beat_we     = 1'b0;
    // Any beat outside collection is a stray, including one coinciding with arm.
    stray_next  = rd_data_valid && (state_reg != C_COLLECT);

    case (state_reg)
      C_IDLE: begin
        if (arm) begin
          tid_next   = cmd_tid;
          rmw_next   = cmd_rmw;
          blen_next  = burst_len;
          cnt_next   = '0;
          err_next   = 1'b0;
          state_next = C_COLLECT;
        end
      end
      C_COLLECT: begin
        if (rd_data_valid) begin
          // Beats past the line capacity are dropped but mark the response.
          if (int'(cnt_reg) < MAX_BEATS) beat_we = 1'b1;
          else                           err_next = 1'b1;
          if (cnt_reg == blen_reg) state_next = C_DONE;
          else                     cnt_next   = cnt_reg + 8'd1;
        end
        // Controller fell back to IDLE: it timed out, deliver what we have.
        if (sm_state == IDLE) begin
          err_next   = 1'b1;
          state_next = C_DONE;
        end
      end
      C_DONE: begin
        if (rmw_reg) begin
          rmw_v_next = 1'b1;
          cnt_next   = '0;
          state_next = C_IDLE;
        end else begin
          resp_v_next = 1'b1;
          state_next  = C_HOLD;
        end
      end
      C_HOLD: begin
        if (resp_v_reg && resp_rdy) begin
          resp_v_next = 1'b0;
          cnt_next    = '0;
          state_next  = C_IDLE;
        end
      end
      default: state_next = C_IDLE;
    endcase
  end

  // One register per line slot; the slot index is the count of prior beats.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_BEATS; gi++) begin : g_slot
      logic [DATA_W-1:0] slot_reg;
      always_ff @(posedge clk) begin
        if (rst)                                slot_reg <= '0;
        else if (beat_we && cnt_reg == 8'(gi))  slot_reg <= rd_data;
      end
      assign resp_line[gi*DATA_W +: DATA_W] = slot_reg;
    end
  endgenerate

`ifdef MPMC11_RESP_LATENCY_EN
  logic [MPMC11_RESP_LAT_W-1:0] lat_cnt_reg;
  logic [MPMC11_RESP_LAT_W-1:0] lat_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt_reg <= '0;
      lat_reg     <= '0;
    end else begin
      if (state_reg == C_IDLE && arm)
        lat_cnt_reg <= '0;
      else if (state_reg == C_COLLECT && lat_cnt_reg != '1)
        lat_cnt_reg <= lat_cnt_reg + 1'b1;
      if (state_reg == C_DONE)
        lat_reg <= lat_cnt_reg;
    end
  end

  assign resp_lat = lat_reg;
`else
  assign resp_lat = '0;
`endif

  assign resp_burst_cnt = cnt_reg;
  assign resp_v         = resp_v_reg;
  assign resp_tid       = tid_reg;
  assign resp_err       = err_reg;
  assign rmw_v          = rmw_v_reg;
  assign busy           = busy_reg;
  assign stray_err      = stray_reg;

endmodule

// File: tb/tb_mpmc11_rd_resp_collector.sv
// Directed bench for mpmc11_rd_resp_collector (default parameters).
module tb_mpmc11_rd_resp_collector;
  import mpmc11_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  mpmc11_state_t       sm_state;
  logic                cmd_cyc, cmd_we, cmd_rmw;
  logic [12:0]         cmd_tid;
  logic [7:0]          burst_len;
  logic                rd_data_valid;
  logic [127:0]        rd_data;
  logic [7:0]          resp_burst_cnt;
  logic                resp_v, resp_rdy;
  logic [12:0]         resp_tid;
  logic [255:0]        resp_line;
  logic                resp_err, rmw_v, busy, stray_err;
  logic [15:0]         resp_lat;

  int checks   = 0;
  int failures = 0;

  logic [127:0] beat_a = {4{32'hAAAA_0001}};
  logic [127:0] beat_b = {4{32'hBBBB_0002}};
  logic [127:0] beat_c = {4{32'hCCCC_0003}};
  logic [127:0] beat_d = {4{32'hDDDD_0004}};
  logic [127:0] beat_e = {4{32'hEEEE_0005}};
  logic [127:0] beat_f = {4{32'hFFFF_0006}};
  logic [127:0] beat_g = {4{32'h1111_0007}};
  logic [127:0] beat_h = {4{32'h2222_0008}};
  logic [127:0] beat_z = {4{32'h3333_0009}};
  logic [127:0] beat_w = {4{32'h4444_000A}};
  logic [255:0] held_line;
  logic [15:0]  exp_lat;

  always #5 clk = ~clk;

  mpmc11_rd_resp_collector dut (
    .clk            (clk),
    .rst            (rst),
    .sm_state       (sm_state),
    .cmd_cyc        (cmd_cyc),
    .cmd_we         (cmd_we),
    .cmd_rmw        (cmd_rmw),
    .cmd_tid        (cmd_tid),
    .burst_len      (burst_len),
    .rd_data_valid  (rd_data_valid),
    .rd_data        (rd_data),
    .resp_burst_cnt (resp_burst_cnt),
    .resp_v         (resp_v),
    .resp_rdy       (resp_rdy),
    .resp_tid       (resp_tid),
    .resp_line      (resp_line),
    .resp_err       (resp_err),
    .rmw_v          (rmw_v),
    .busy           (busy),
    .stray_err      (stray_err),
    .resp_lat       (resp_lat)
  );

  // Arming while busy is upstream misuse; the stimulus must never do it.
  always @(negedge clk) begin
    if (!rst && sm_state == PRESET3 && cmd_cyc && !cmd_we && busy) begin
      failures++;
      $error("FAIL arm_while_busy observed=busy expected=idle");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents an arm for one cycle, then returns the controller to RD_WAIT.
  task automatic arm(input logic rmw, input logic [12:0] tid, input logic [7:0] blen);
    sm_state  = PRESET3;
    cmd_cyc   = 1'b1;
    cmd_we    = 1'b0;
    cmd_rmw   = rmw;
    cmd_tid   = tid;
    burst_len = blen;
    step();
    sm_state  = RD_WAIT;
    cmd_cyc   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sm_state = RD_WAIT; cmd_cyc = 1'b0; cmd_we = 1'b0; cmd_rmw = 1'b0;
    cmd_tid = '0; burst_len = '0; rd_data_valid = 1'b0; rd_data = '0; resp_rdy = 1'b0;
`ifdef MPMC11_RESP_LATENCY_EN
    exp_lat = 16'd7;
`else
    exp_lat = 16'd0;
`endif
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_resp_v", resp_v, 0);
    chk("rst_rmw_v", rmw_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", resp_burst_cnt, 0);
    chk("rst_line", resp_line, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_stray", stray_err, 0);
    chk("rst_tid", resp_tid, 0);
    chk("rst_lat", resp_lat, 0);
    $display("TXN reset done");

    // Two-beat read with backpressure
    arm(1'b0, 13'h0A5, 8'd1);
    chk("two_busy", busy, 1);
    rd_data_valid = 1'b1; rd_data = beat_a;
    chk("two_cnt0", resp_burst_cnt, 0);
    step();
    rd_data = beat_b;
    chk("two_cnt1", resp_burst_cnt, 1);
    step();
    rd_data_valid = 1'b0;
    chk("two_resp_v_n1", resp_v, 0);
    step();
    chk("two_resp_v_n2", resp_v, 1);
    chk("two_line", resp_line, {beat_b, beat_a});
    chk("two_err", resp_err, 0);
    chk("two_tid", resp_tid, 13'h0A5);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_resp_v", resp_v, 1);
      chk("bp_line", resp_line, {beat_b, beat_a});
    end
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    chk("bp_resp_v_drop", resp_v, 0);
    chk("bp_busy_drop", busy, 0);
    $display("TXN two_beat tid=%0h line=%0h", resp_tid, resp_line);

    // RMW single beat
    arm(1'b1, 13'h111, 8'd0);
    rd_data_valid = 1'b1; rd_data = beat_c;
    step();
    rd_data_valid = 1'b0;
    chk("rmw_v_early", rmw_v, 0);
    step();
    chk("rmw_v_pulse", rmw_v, 1);
    chk("rmw_resp_v", resp_v, 0);
    chk("rmw_busy", busy, 0);
    chk("rmw_line_lo", resp_line[127:0], beat_c);
    chk("rmw_err", resp_err, 0);
    step();
    chk("rmw_v_single", rmw_v, 0);
    $display("TXN rmw line_lo=%0h", resp_line[127:0]);

    // Timeout abort: upper slot still holds beat_b from the first read
    arm(1'b0, 13'h1FFF, 8'd1);
    rd_data_valid = 1'b1; rd_data = beat_d;
    step();
    rd_data_valid = 1'b0;
    sm_state = IDLE;
    chk("abort_cnt", resp_burst_cnt, 1);
    step();
    sm_state = RD_WAIT;
    step();
    chk("abort_resp_v", resp_v, 1);
    chk("abort_err", resp_err, 1);
    chk("abort_line", resp_line, {beat_b, beat_d});
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    chk("abort_drop", resp_v, 0);
    $display("TXN abort err=%0d line=%0h", resp_err, resp_line);

    // Overflow: four beats into a two-beat line
    arm(1'b0, 13'h005, 8'd3);
    rd_data_valid = 1'b1;
    rd_data = beat_e; step();
    rd_data = beat_f; step();
    rd_data = beat_g; step();
    chk("ovf_cnt3", resp_burst_cnt, 3);
    rd_data = beat_h; step();
    rd_data_valid = 1'b0;
    step();
    chk("ovf_resp_v", resp_v, 1);
    chk("ovf_line", resp_line, {beat_f, beat_e});
    chk("ovf_err", resp_err, 1);
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    chk("ovf_drop", resp_v, 0);
    $display("TXN overflow err=%0d line=%0h", resp_err, resp_line);

    // Stray beat in C_IDLE
    held_line = resp_line;
    rd_data_valid = 1'b1; rd_data = beat_z;
    step();
    rd_data_valid = 1'b0;
    chk("stray_idle", stray_err, 1);
    chk("stray_cnt", resp_burst_cnt, 0);
    chk("stray_busy", busy, 0);
    chk("stray_line", resp_line, held_line);
    step();
    chk("stray_pulse", stray_err, 0);
    $display("TXN stray_idle");

    // Latency: last beat seven cycles after arm; stray during C_HOLD
    arm(1'b0, 13'h042, 8'd0);
    repeat (6) step();
    rd_data_valid = 1'b1; rd_data = beat_w;
    step();
    rd_data_valid = 1'b0;
    step();
    chk("lat_resp_v", resp_v, 1);
    chk("lat_value", resp_lat, exp_lat);
    rd_data_valid = 1'b1; rd_data = beat_z;
    step();
    rd_data_valid = 1'b0;
    chk("hold_stray", stray_err, 1);
    chk("hold_resp_v", resp_v, 1);
    chk("hold_line_lo", resp_line[127:0], beat_w);
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    $display("TXN latency lat=%0d", resp_lat);

    // Arm and stray beat together: beat is a stray, not stored
    sm_state = PRESET3; cmd_cyc = 1'b1; cmd_we = 1'b0; cmd_rmw = 1'b0;
    cmd_tid = 13'h077; burst_len = 8'd0;
    rd_data_valid = 1'b1; rd_data = beat_z;
    step();
    sm_state = RD_WAIT; cmd_cyc = 1'b0;
    chk("armstray_stray", stray_err, 1);
    chk("armstray_cnt", resp_burst_cnt, 0);
    rd_data = beat_a;
    step();
    rd_data_valid = 1'b0;
    step();
    chk("armstray_resp_v", resp_v, 1);
    chk("armstray_line_lo", resp_line[127:0], beat_a);
    resp_rdy = 1'b1;
    step();
    resp_rdy = 1'b0;
    $display("TXN arm_with_stray line_lo=%0h", resp_line[127:0]);

    // Reset mid-burst discards everything
    arm(1'b0, 13'h0AA, 8'd1);
    rd_data_valid = 1'b1; rd_data = beat_b;
    step();
    rd_data_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", resp_burst_cnt, 0);
    chk("midrst_line", resp_line, 0);
    step(); step();
    chk("midrst_resp_v", resp_v, 0);
    $display("TXN mid_burst_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mpmc11_rd_resp_collector.md
Name: mpmc11_rd_resp_collector

Overview:
- Sits directly downstream of the mpmc11 controller state machine, on the memory-controller read-return path.
- Counts and assembles read-data beats returned by the DDR application interface into one line, and produces the `resp_burst_cnt` the state machine compares against `burst_len`.
- Delivers the assembled line either to the requesting channel (response handshake) or to the RMW/ALU path.
- Also flags stray, overflow and aborted bursts.

Parameters:
- DATA_W, 128, width of one application read-data beat.
- MAX_BEATS, 2, beats stored per line; line width = DATA_W*MAX_BEATS.
- TID_W, 13, width of the transaction id carried with the response.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- sm_state  in  mpmc11_state_t  current controller state
- cmd_cyc  in  1  latched command cycle bit (fifo_out.cyc)
- cmd_we  in  1  latched command write bit (fifo_out.we)
- cmd_rmw  in  1  command is an ALU/CAS read-modify-write
- cmd_tid  in  TID_W  transaction id of the command
- burst_len  in  8  beats-1 of the current burst
- rd_data_valid  in  1  application read beat valid
- rd_data  in  DATA_W  application read beat
- resp_burst_cnt  out  8  beats received so far in the current burst
- resp_v  out  1  channel response valid
- resp_rdy  in  1  channel accepts response
- resp_tid  out  TID_W  id returned with the response
- resp_line  out  DATA_W*MAX_BEATS  assembled line
- resp_err  out  1  response is from an aborted/overflowed burst
- rmw_v  out  1  one-cycle pulse: line valid for the ALU path
- busy  out  1  collector is not idle; upstream gates new reads
- stray_err  out  1  one-cycle pulse: beat arrived while not collecting
- resp_lat  out  16  arm-to-last-beat latency (optional feature)

Behaviour:
- Reset: every output is 0 and the collector state is C_IDLE. Reset mid-burst discards the partial line with no response.
- States:
  - C_IDLE
    - Arms when `sm_state==PRESET3 && cmd_cyc && !cmd_we`.
    - On arm: latch `cmd_tid`, `cmd_rmw` and `burst_len`; clear the count and `resp_err`; go to C_COLLECT.
    - A beat arriving in C_IDLE is dropped and `stray_err` pulses the next cycle.
  - C_COLLECT
    - On `rd_data_valid`: write the beat to `line[cnt*DATA_W +: DATA_W]` when `cnt<MAX_BEATS`. When `cnt>=MAX_BEATS`, drop the beat and set `resp_err` (overflow).
    - On a valid beat with `cnt!=latched burst_len`: `cnt` increments.
    - On a valid beat with `cnt==latched burst_len`: this is the last beat; go to C_DONE.
    - `resp_burst_cnt` equals `cnt` combinationally from the register, so the state machine sees the count of prior beats during the current beat.
    - Abort: `sm_state==IDLE` while in C_COLLECT (controller timeout). Set `resp_err=1` and go to C_DONE with the partial line.
  - C_DONE
    - Lasts one cycle.
    - If the latched rmw is set: pulse `rmw_v` with `resp_line` and go to C_IDLE. An aborted RMW also pulses `rmw_v`, with `resp_err=1`.
    - Otherwise assert `resp_v` and go to C_HOLD.
  - C_HOLD
    - `resp_v`, `resp_tid`, `resp_line` and `resp_err` are held stable until `resp_rdy`.
    - On `resp_v && resp_rdy`: deassert `resp_v` the next cycle and go to C_IDLE.
    - Rule: `resp_v` never drops without `resp_rdy`.
- Latency: the last beat at cycle N gives `resp_v` or `rmw_v` at N+2. There is no combinational path from `rd_data` to the outputs.
- `busy` = (state != C_IDLE), registered with the state.
- An arm condition while busy is ignored. This is legal only through upstream misuse; a bench assertion flags it.
- `rd_data_valid` in C_DONE or C_HOLD is a stray: dropped, `stray_err` pulses.
- Simultaneous arm and stray beat in C_IDLE: arm wins, the beat is counted as a stray.
- `cnt` is 8 bits; `burst_len=255` is legal and non-stored beats only set overflow. `cnt` does not wrap within a burst.

Optional Feature:
- MPMC11_RESP_LATENCY_EN
- Defined:
  - A 16-bit counter clears on arm and increments every cycle in C_COLLECT, saturating at 16'hFFFF.
  - Its value is captured into `resp_lat` in C_DONE and held with the response.
- Undefined: `resp_lat` is tied to 0 and the counter is not built.

Decomposition:
- mpmc11_pkg gains:
  - `mpmc11_coll_state_t` (C_IDLE, C_COLLECT, C_DONE, C_HOLD)
  - `MPMC11_RESP_LAT_W=16`
- No sub-module; the datapath is small enough to stay flat. The optional latency counter is a generate-free `ifdef` block inline.

Test Plan:
- Two-beat read: `burst_len=1`, beats A,B on cycles 10,11 -> `resp_burst_cnt` 0 then 1, `resp_v` at 13, `resp_line={B,A}`, `resp_err=0`.
- Backpressure: `resp_rdy` low for 5 cycles -> `resp_v` and `resp_line` stable for all 5, drops the cycle after `resp_rdy`, `busy` falls the same cycle.
- RMW: `cmd_rmw=1`, `burst_len=0`, one beat -> `rmw_v` single pulse two cycles later, `resp_v` stays 0.
- Timeout abort: `burst_len=1`, one beat, then `sm_state=IDLE` -> `resp_v` with `resp_err=1`, upper half of the line unchanged.
- Overflow: `MAX_BEATS=2`, `burst_len=3`, four beats -> first two stored, `resp_err=1`.
- Strays and latency: a beat in C_IDLE -> `stray_err` pulse, `resp_burst_cnt` stays 0. With `MPMC11_RESP_LATENCY_EN`, last beat 7 cycles after arm -> `resp_lat=7`.
